sb_color_scan_scheduler: RTL and testbench
==========================================

# sb_color_scan_scheduler

Sequencer and arbiter for the shared TCS3200 colour sensor and its frequency counter. Up to N_REQ requesters, such as the line-follow and node-detect logic, request a colour read. The block grants one requester at a time in round-robin order and steps the sensor filter through clear, red, blue and green. For each filter it restarts the counter, waits a settle window and latches the count, then classifies the colour and returns it tagged with the requester id.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..4)
- CNT_W, 14, width of the frequency-counter count
- SETTLE_CYCLES, 5000000, clk cycles spent waiting per filter before sampling (≥1)
- WHITE_THRESH, 300, clear-filter count below which the colour is white

Ports:
- clk, in, 1, system clock
- rst, in, 1, asynchronous, active-high reset
- req, in, N_REQ, level request per requester; sampled only in IDLE
- grant, out, N_REQ, one-hot; held from scan start through the DONE cycle
- s2, out, 1, sensor filter select S2
- s3, out, 1, sensor filter select S3
- cnt_clear, out, 1, one-cycle pulse that restarts the counter measurement
- count, in, CNT_W, count from the frequency counter
- result_valid, out, 1, one-cycle pulse when a colour is available
- result_id, out, clog2(N_REQ), index of the requester that was served
- color, out, 3, {R,G,B} code: 111 white, 100 red, 010 green, 001 blue

## Operation
- Reset values: grant=0, s2=1, s3=0 (clear filter), cnt_clear=0, result_valid=0, result_id=0, color=000, RR pointer=0, all latched counts=0, state=IDLE.
- Filter encodings {s2,s3}: clear 10, red 00, blue 01, green 11.
- State sequence: IDLE → SET_C → WAIT → SAMP_C → (white ? DONE : SET_R) → WAIT → SAMP_R → SET_B → WAIT → SAMP_B → SET_G → WAIT → SAMP_G → DECIDE → DONE → IDLE.
- IDLE: if req≠0, the round-robin arbiter picks the first set bit at or after the pointer. grant becomes one-hot next cycle. The pointer moves to winner+1, modulo N_REQ.
- SET_x: drive s2/s3 for filter x; cnt_clear=1 for this cycle only.
- WAIT: the settle counter runs for SETTLE_CYCLES cycles, then the block goes to SAMP_x.
- SAMP_x: latch count into the c/r/b/g register.
- At SAMP_C: if c_count < WHITE_THRESH, set color_next=111 and go to DONE; the RGB phases are skipped.
- DECIDE, using strict compares:
  - r<g and r<b → 100
  - r<g and r≥b → 001
  - r≥g and g<b → 010
  - otherwise → 001
  - Ties therefore resolve toward blue, then green.
- DONE: color and result_id update; result_valid=1 for one cycle. Next cycle: grant=0, s2/s3 return to clear (10), state=IDLE.
- color holds its value between results.
- If req drops mid-scan, the scan still completes and the result is still issued. req is not re-sampled until IDLE.
- New requests during a scan wait. A requester that holds req high is served again only after every other pending requester (round-robin).
- An asynchronous reset mid-scan aborts immediately to reset values. No result_valid is produced.

## Timing
- Let t be the first cycle grant is high, which is one cycle after req is sampled in IDLE; the block is in SET_C at t.
- Each filter phase lasts SETTLE_CYCLES+2 cycles (SET + WAIT + SAMP).
- White result: result_valid at t+(SETTLE_CYCLES+2).
- Full scan: result_valid at t+4·(SETTLE_CYCLES+2)+1.
- Back-to-back: the earliest next grant is 2 cycles after result_valid (IDLE, then the new SET_C).
- cnt_clear is asserted in the same cycle as the new s2/s3 value.

## Structure
- Package sb_color_pkg holds:
  - colour codes (COL_WHITE, COL_RED, COL_GREEN, COL_BLUE)
  - filter select constants (FLT_CLEAR, FLT_RED, FLT_BLUE, FLT_GREEN)
  - the scan state enum
- Sub-module sb_rr_arbiter (parameter N_REQ) has inputs req, enable and pointer, and outputs a one-hot winner and its index. It is purely combinational. The scheduler owns the pointer register.
- The settle counter is sized clog2(SETTLE_CYCLES+1) bits.

## Test plan
All scenarios use SETTLE_CYCLES=4.
- White: req=01, count=120 during clear → grant=01; result_valid at t+6 with color=111, id=0; s2/s3 observed only as 10.
- Red: req=10, counts c=900, r=200, b=700, g=650 → s2/s3 sequence 10, 00, 01, 11; result_valid at t+25 with color=100, id=1.
- Tie: c=900, r=400, g=400, b=400 → color=001; with r=500, g=300, b=300 → color=001; with r=500, g=300, b=800 → color=010.
- Round-robin: req=11 held for 3 scans → grant order 01, 10, 01; result_ids 0, 1, 0; grant never has two bits set.
- Withdraw: req=01 pulsed for 1 cycle → full scan still completes and one result_valid is issued.
- Reset: assert rst in the WAIT state of the blue phase → outputs go to reset values immediately with no result_valid; after release, a req=01 scan behaves normally from SET_C.

Source files
------------

// File: rtl/sb_color_pkg.sv
// sb_color_pkg
// Shared definitions for the colour-sensor scan scheduler:
//   - 3-bit {R,G,B} colour codes returned with each result
//   - {S2,S3} filter-select encodings for the TCS3200
//   - scan state and filter-phase enums
//   - phase_filter(): maps a filter phase to its {S2,S3} select value
package sb_color_pkg;

  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b001;

  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  // SET, WAIT and SAMP are shared by all four filters; the phase register
  // says which filter the scan is currently working on.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_WAIT,
    ST_SAMP,
    ST_DECIDE,
    ST_DONE
  } scan_state_e;

  // Filter phases in scan order. The value also indexes the latched-count array.
  typedef enum logic [1:0] {
    PH_CLEAR,
    PH_RED,
    PH_BLUE,
    PH_GREEN
  } scan_phase_e;

  function automatic logic [1:0] phase_filter(input scan_phase_e ph);
    logic [1:0] flt;
    unique case (ph)
      PH_CLEAR: flt = FLT_CLEAR;
      PH_RED:   flt = FLT_RED;
      PH_BLUE:  flt = FLT_BLUE;
      PH_GREEN: flt = FLT_GREEN;
      default:  flt = FLT_CLEAR;
    endcase
    return flt;
  endfunction

endpackage

// File: rtl/sb_rr_arbiter.sv
// sb_rr_arbiter
// Purely combinational round-robin pick: returns the first set request bit
// at or after pointer_i, wrapping modulo N_REQ. The caller owns the pointer.
// Ports:
//   req_i      [N_REQ]  request vector
//   enable_i            when low, no winner is produced
//   pointer_i  [IDX_W]  highest-priority requester index
//   winner_o   [N_REQ]  one-hot winner (zero if no request or disabled)
//   index_o    [IDX_W]  index of the winner (zero if none)
module sb_rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic             enable_i,
  input  logic [IDX_W-1:0] pointer_i,
  output logic [N_REQ-1:0] winner_o,
  output logic [IDX_W-1:0] index_o
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    winner_o = '0;
    index_o  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (enable_i) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand     = (int'(pointer_i) + k) % N_REQ;
        cand_idx = IDX_W'(cand);
        if (!found && req_i[cand_idx]) begin
          winner_o[cand_idx] = 1'b1;
          index_o            = cand_idx;
          found              = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sb_color_scan_scheduler.sv
// sb_color_scan_scheduler
// Arbitrates the shared TCS3200 colour sensor between N_REQ requesters and
// runs one colour scan per grant: clear, red, blue, green filters, each with
// a counter restart, a settle window and a count sample. A low clear count
// short-cuts to white; otherwise the RGB counts are compared (a smaller
// period count means a stronger channel).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_i        [N]    level requests, sampled only while idle
//   grant_o      [N]    one-hot grant, held for the whole scan incl. DONE
//   s2_o, s3_o          sensor filter select
//   cnt_clear_o         one-cycle restart of the frequency counter
//   count_i      [CNT_W] frequency-counter result
//   result_valid_o      one-cycle pulse with a new colour
//   result_id_o  [ID_W] requester that was served
//   color_o      [3]    {R,G,B} colour code, held between results
module sb_color_scan_scheduler
  import sb_color_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int CNT_W         = 14,
  parameter int SETTLE_CYCLES = 5000000,
  parameter int WHITE_THRESH  = 300,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_i,
  output logic [N_REQ-1:0]  grant_o,
  output logic              s2_o,
  output logic              s3_o,
  output logic              cnt_clear_o,
  input  logic [CNT_W-1:0]  count_i,
  output logic              result_valid_o,
  output logic [ID_W-1:0]   result_id_o,
  output logic [2:0]        color_o
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  scan_state_e      state_q, state_d;
  scan_phase_e      phase_q, phase_d;
  logic [SET_W-1:0] settle_q, settle_d;

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  result_id_q, result_id_d;
  logic [2:0]       color_q, color_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  logic             arb_enable;
  logic [N_REQ-1:0] arb_winner;
  logic [ID_W-1:0]  arb_index;
  logic             white_now;

  // Strict compares, so ties fall through toward blue, then green.
  function automatic logic [2:0] decide_rgb(input logic [CNT_W-1:0] r,
                                            input logic [CNT_W-1:0] g,
                                            input logic [CNT_W-1:0] b);
    logic [2:0] col;
    if (r < g && r < b)  col = COL_RED;
    else if (r < g)      col = COL_BLUE;
    else if (g < b)      col = COL_GREEN;
    else                 col = COL_BLUE;
    return col;
  endfunction

  assign arb_enable = (state_q == ST_IDLE);
  // The clear count is judged as it is being latched, so the white
  // decision costs no extra cycle.
  assign white_now  = (count_i < CNT_W'(WHITE_THRESH));

  sb_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req_i    (req_i),
    .enable_i (arb_enable),
    .pointer_i(ptr_q),
    .winner_o (arb_winner),
    .index_o  (arb_index)
  );

  // State register: scan state, current filter phase and settle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_CLEAR;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic. The phase advances when leaving SAMP so that the new
  // filter is already selected in the following SET cycle.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_SET;
          phase_d = PH_CLEAR;
        end
      end
      ST_SET: begin
        state_d  = ST_WAIT;
        settle_d = '0;
      end
      ST_WAIT: begin
        if (settle_q == SETTLE_LAST) state_d = ST_SAMP;
        else                         settle_d = settle_q + 1'b1;
      end
      ST_SAMP: begin
        unique case (phase_q)
          PH_CLEAR: begin
            if (white_now) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SET;
              phase_d = PH_RED;
            end
          end
          PH_RED: begin
            state_d = ST_SET;
            phase_d = PH_BLUE;
          end
          PH_BLUE: begin
            state_d = ST_SET;
            phase_d = PH_GREEN;
          end
          default: state_d = ST_DECIDE;
        endcase
      end
      ST_DECIDE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: arbitration pointer, grant, served id, latched
  // counts and the published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      id_q        <= '0;
      result_id_q <= '0;
      color_q     <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      id_q        <= id_d;
      result_id_q <= result_id_d;
      color_q     <= color_d;
      cnt_q       <= cnt_d;
    end
  end

  // Datapath next values. The colour and id are loaded on the way into
  // DONE so they are visible together with result_valid.
  always_comb begin
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    id_d        = id_q;
    result_id_d = result_id_q;
    color_d     = color_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          grant_d = arb_winner;
          id_d    = arb_index;
          ptr_d   = (arb_index == ID_W'(N_REQ - 1)) ? '0 : arb_index + 1'b1;
        end
      end
      ST_SAMP: begin
        cnt_d[phase_q] = count_i;
        if (phase_q == PH_CLEAR && white_now) begin
          color_d     = COL_WHITE;
          result_id_d = id_q;
        end
      end
      ST_DECIDE: begin
        color_d     = decide_rgb(cnt_q[PH_RED], cnt_q[PH_GREEN], cnt_q[PH_BLUE]);
        result_id_d = id_q;
      end
      ST_DONE: grant_d = '0;
      default: ;
    endcase
  end

  // Outputs decoded from the current state. Idle always parks the sensor
  // on the clear filter.
  always_comb begin
    cnt_clear_o    = (state_q == ST_SET);
    result_valid_o = (state_q == ST_DONE);
    {s2_o, s3_o}   = (state_q == ST_IDLE) ? FLT_CLEAR : phase_filter(phase_q);
  end

  assign grant_o     = grant_q;
  assign result_id_o = result_id_q;
  assign color_o     = color_q;

endmodule

// File: tb/tb_sb_color_scan_scheduler.sv
// tb_sb_color_scan_scheduler
// Self-checking bench for sb_color_scan_scheduler with SETTLE_CYCLES=4.
// A sensor model feeds count according to the selected filter; expected
// colours, ids and latencies come from the bench's own reference rules.
module tb_sb_color_scan_scheduler;

  localparam int N_REQ     = 2;
  localparam int CNT_W     = 14;
  localparam int SETTLE    = 4;
  localparam int WHITE     = 300;
  localparam int PHASE_LEN = SETTLE + 2;

  typedef struct {
    logic [1:0] req;
    int         c;
    int         r;
    int         b;
    int         g;
    logic [2:0] expColor;
    int         expId;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [1:0]       grant;
  logic             s2, s3;
  logic             cntClear;
  logic [CNT_W-1:0] count;
  logic             resultValid;
  logic [0:0]       resultId;
  logic [2:0]       color;

  int cC = 0, cR = 0, cB = 0, cG = 0;
  int nVec = 0, nBad = 0;
  int modelPtr = 0;
  vec_t vecs [8];

  sb_color_scan_scheduler #(
    .N_REQ(N_REQ), .CNT_W(CNT_W), .SETTLE_CYCLES(SETTLE), .WHITE_THRESH(WHITE)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .grant_o(grant), .s2_o(s2), .s3_o(s3),
    .cnt_clear_o(cntClear), .count_i(count), .result_valid_o(resultValid),
    .result_id_o(resultId), .color_o(color)
  );

  always #5 clk = ~clk;

  // Sensor model: the counter reports the count of whichever filter is selected.
  always_comb begin
    count = CNT_W'(cG);
    case ({s2, s3})
      2'b10:   count = CNT_W'(cC);
      2'b00:   count = CNT_W'(cR);
      2'b01:   count = CNT_W'(cB);
      default: count = CNT_W'(cG);
    endcase
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVec++;
    if (actual != expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Colour rule: white on a dim clear reading, red only if strictly the
  // smallest, green if strictly below blue and not above red, else blue.
  function automatic logic [2:0] refColor(input int c, input int r, input int g, input int b);
    if (c < WHITE)              return 3'b111;
    if (r < g && r < b)         return 3'b100;
    if (g < b && g <= r)        return 3'b010;
    return 3'b001;
  endfunction

  function automatic int rrPick(input logic [1:0] reqv);
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (modelPtr + k) % N_REQ;
      if (reqv[j]) return j;
    end
    return 0;
  endfunction

  // Runs one complete scan from IDLE and checks grant, filter sequence,
  // counter restarts, latency and result. Ends at the IDLE cycle after DONE.
  task automatic applyStimulus(input string name, input logic [1:0] reqv, input bit pulse,
                               input bit keep, input logic [2:0] expColor, input int expId);
    int w, lat, pulses, seqLen, grantBad, alignBad, expLat, expLen;
    logic [7:0] seqVal, expSeq;
    logic [1:0] lastF, expGrant;
    expGrant = 2'(1 << expId);
    expLat   = (expColor == 3'b111) ? PHASE_LEN : 4 * PHASE_LEN + 1;
    expLen   = (expColor == 3'b111) ? 1 : 4;
    expSeq   = (expColor == 3'b111) ? 8'h02 : 8'h87;
    req = reqv;
    w = 0;
    while (w < 8) begin
      @(negedge clk);
      w++;
      if (pulse) req = 2'b00;
      if (grant != 2'b00) break;
    end
    checkOutput({name, "/grant_latency"}, w, 1);
    if (grant == 2'b00) begin
      req = 2'b00;
      return;
    end
    modelPtr = (expId + 1) % N_REQ;
    checkOutput({name, "/grant"}, int'(grant), int'(expGrant));
    checkOutput({name, "/start_filter"}, int'({s2, s3}), 2);
    pulses   = int'(cntClear);
    seqVal   = {6'b0, s2, s3};
    seqLen   = 1;
    lastF    = {s2, s3};
    lat      = -1;
    grantBad = 0;
    alignBad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if ({s2, s3} != lastF) begin
        seqVal = {seqVal[5:0], s2, s3};
        seqLen++;
        lastF = {s2, s3};
        if (!cntClear) alignBad++;
      end
      pulses += int'(cntClear);
      if (grant != expGrant) grantBad++;
      if (resultValid) begin
        lat = k;
        break;
      end
    end
    checkOutput({name, "/latency"}, lat, expLat);
    checkOutput({name, "/color"}, int'(color), int'(expColor));
    checkOutput({name, "/id"}, int'(resultId), expId);
    checkOutput({name, "/cnt_clear_pulses"}, pulses, expLen);
    checkOutput({name, "/filter_count"}, seqLen, expLen);
    checkOutput({name, "/filter_seq"}, int'(seqVal), int'(expSeq));
    checkOutput({name, "/grant_stable"}, grantBad, 0);
    checkOutput({name, "/clear_align"}, alignBad, 0);
    if (!keep) req = 2'b00;
    @(negedge clk);
    checkOutput({name, "/post_valid"}, int'(resultValid), 0);
    checkOutput({name, "/post_grant"}, int'(grant), 0);
    checkOutput({name, "/post_filter"}, int'({s2, s3}), 2);
    checkOutput({name, "/color_hold"}, int'(color), int'(expColor));
  endtask

  task automatic setCounts(input int c, input int r, input int b, input int g);
    cC = c; cR = r; cB = b; cG = g;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w, sawValid, sawGrant, rid;
    logic [1:0] rreq;
    logic [2:0] rcol;

    vecs[0] = '{2'b01, 120, 0,   0,   0,   3'b111, 0};
    vecs[1] = '{2'b10, 900, 200, 700, 650, 3'b100, 1};
    vecs[2] = '{2'b01, 900, 400, 400, 400, 3'b001, 0};
    vecs[3] = '{2'b01, 900, 500, 300, 300, 3'b001, 0};
    vecs[4] = '{2'b10, 900, 500, 800, 300, 3'b010, 1};
    vecs[5] = '{2'b01, 299, 10,  10,  10,  3'b111, 0};
    vecs[6] = '{2'b10, 300, 100, 50,  100, 3'b001, 1};
    vecs[7] = '{2'b11, 900, 100, 100, 200, 3'b001, 0};

    repeat (3) @(negedge clk);
    checkOutput("reset/grant", int'(grant), 0);
    checkOutput("reset/filter", int'({s2, s3}), 2);
    checkOutput("reset/cnt_clear", int'(cntClear), 0);
    checkOutput("reset/valid", int'(resultValid), 0);
    checkOutput("reset/id", int'(resultId), 0);
    checkOutput("reset/color", int'(color), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      setCounts(vecs[i].c, vecs[i].r, vecs[i].b, vecs[i].g);
      applyStimulus($sformatf("vec%0d", i), vecs[i].req, 1'b0, 1'b0,
                    vecs[i].expColor, vecs[i].expId);
    end

    // Held double request: the served requester must yield to the other.
    setCounts(120, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      rid = rrPick(2'b11);
      applyStimulus($sformatf("rr%0d", i), 2'b11, 1'b0, (i < 2), 3'b111, rid);
    end

    for (int i = 0; i < 12; i++) begin
      rreq = 2'($urandom_range(1, 3));
      setCounts(int'($urandom_range(150, 1000)), int'($urandom_range(0, 7)) * 100,
                int'($urandom_range(0, 7)) * 100, int'($urandom_range(0, 7)) * 100);
      rcol = refColor(cC, cR, cG, cB);
      rid  = rrPick(rreq);
      applyStimulus($sformatf("rand%0d", i), rreq, 1'b0, 1'b0, rcol, rid);
    end

    // One-cycle request pulse: the scan still completes exactly once.
    setCounts(900, 200, 700, 650);
    applyStimulus("withdraw", 2'b01, 1'b1, 1'b0, 3'b100, rrPick(2'b01));
    sawValid = 0;
    repeat (30) begin
      @(negedge clk);
      sawValid += int'(resultValid);
    end
    checkOutput("withdraw/extra_valid", sawValid, 0);

    // Reset during the blue-phase settle window.
    setCounts(900, 200, 700, 650);
    req = 2'b01;
    w = 0;
    while (w < 8) begin
      @(negedge clk);
      w++;
      if (grant != 2'b00) break;
    end
    checkOutput("abort/grant_latency", w, 1);
    repeat (2 * PHASE_LEN + 2) @(negedge clk);
    checkOutput("abort/blue_filter", int'({s2, s3}), 1);
    req = 2'b00;
    #2 rst = 1'b1;
    #1;
    checkOutput("abort/grant", int'(grant), 0);
    checkOutput("abort/filter", int'({s2, s3}), 2);
    checkOutput("abort/cnt_clear", int'(cntClear), 0);
    checkOutput("abort/valid", int'(resultValid), 0);
    checkOutput("abort/id", int'(resultId), 0);
    checkOutput("abort/color", int'(color), 0);
    modelPtr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sawValid = 0;
    sawGrant = 0;
    repeat (30) begin
      @(negedge clk);
      sawValid += int'(resultValid);
      sawGrant += int'(grant != 2'b00);
    end
    checkOutput("abort/no_valid", sawValid, 0);
    checkOutput("abort/no_grant", sawGrant, 0);
    applyStimulus("post_reset", 2'b01, 1'b0, 1'b0, 3'b100, rrPick(2'b01));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
